demux_lanes: RTL and testbench
==============================

# demux_lanes

Two-lane demultiplexer: the receive-side counterpart of the two-lane arbitrating mux. Takes the single byte stream produced at the 2f word rate, plus a lane tag, and steers each valid word back to lane 0 or lane 1. Each lane has a small holding FIFO, so a downstream pause does not lose data until that FIFO overflows. Runs entirely on clk8f and derives the 2f word-rate strobe internally.

## Interface
- DATA_W, 8, width of data words.
- DEPTH, 4, per-lane holding FIFO depth in words; power of two, at least 2.

- clk8f  input  1  fast clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low.
- data_in_c  input  DATA_W  input word.
- valid_in_c  input  1  input word valid; sampled only on strobe edges.
- lane_in_c  input  1  destination lane of the input word (0 or 1); ignored when valid_in_c=0.
- pause_0  input  1  lane 0 downstream not ready; sampled on strobe edges.
- pause_1  input  1  lane 1 downstream not ready; sampled on strobe edges.
- data_out_0_c  output  DATA_W  lane 0 word; 0 when valid_out_0_c=0.
- valid_out_0_c  output  1  lane 0 word valid; held for one word period (4 clk8f cycles).
- data_out_1_c  output  DATA_W  lane 1 word; 0 when valid_out_1_c=0.
- valid_out_1_c  output  1  lane 1 word valid.
- overflow_0  output  1  sticky: a lane 0 word was dropped.
- overflow_1  output  1  sticky: a lane 1 word was dropped.

## Operation
- FSM states: RESET, WAIT, RUN.
  - RESET: entered on any edge with reset=0, from any state, including mid-transfer.
  - RESET -> WAIT on the first edge with reset=1.
  - WAIT -> RUN on the first strobe edge.
  - RUN stays in RUN until reset.
- Phase counter:
  - 2 bits; held at 0 in RESET; increments by 1 (mod 4) on every edge outside RESET.
  - strobe = (phase == 3). All sampling and output updates happen only on strobe edges.
- Push (strobe edge, WAIT or RUN):
  - If valid_in_c=1, write data_in_c into the FIFO of lane lane_in_c.
  - If that FIFO is full and is not popped on the same edge, drop the word and set that lane's overflow flag.
- Pop (strobe edge, per lane, independently):
  - If the FIFO is non-empty and pause_x=0: move the head word to data_out_x_c and set valid_out_x_c=1.
  - Otherwise: data_out_x_c=0 and valid_out_x_c=0.
- Simultaneous push and pop on the same lane:
  - The pop takes the old head; the push is accepted even when the FIFO is full.
  - Occupancy is unchanged.
- Order within a lane is preserved. Lanes never block each other.
- Overflow flags clear only in RESET.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.

## Timing
- Reset values, applied on any edge with reset=0:
  - all outputs 0
  - FIFOs empty, phase 0, state RESET.
- First strobe edge is the 4th rising edge with reset=1 (phases 0->1->2->3, then sample).
- Latency: a word sampled at strobe k, going to an empty unpaused lane, appears on that lane's outputs right after strobe k+1 (4 clk8f cycles).
- Outputs change only on strobe edges (or reset) and are stable for 4 clk8f cycles.
- Throughput: one input word per strobe.
  - Lane alternation sustains full rate.
  - A lane with a continuous stream and no pause never overflows.
- Reset asserted mid-operation: buffered words are discarded; no partial output is visible on the following edge.

## Test plan
- Reset check:
  - Stimulus: hold reset=0 for 8 edges with valid_in_c=1, then release.
  - Required: all outputs stay 0 during reset; the first sample occurs on the 4th edge after release.
- Alternating lanes:
  - Stimulus: words 0xA1 (lane 0), 0xB2 (lane 1), 0xA3 (lane 0) on consecutive strobes.
  - Required: lane 0 outputs 0xA1 then, two word periods later, 0xA3; lane 1 outputs 0xB2, one word period after each input.
- Pause buffering:
  - Stimulus: pause_0=1; send 0x11, 0x22, 0x33 to lane 0; then pause_0=0.
  - Required: outputs 0x11, 0x22, 0x33 on three consecutive word periods; overflow_0 stays 0.
- Overflow:
  - Stimulus: pause_1=1; send 5 words 0x01..0x05 to lane 1 (DEPTH=4); release the pause.
  - Required: output is 0x01..0x04; 0x05 is dropped; overflow_1=1 and stays set until reset.
- Full with simultaneous pop:
  - Stimulus: lane 0 FIFO full; pause_0 goes 0 on the same strobe that a new word 0x5A arrives.
  - Required: 0x5A is accepted and emitted last, in order; no overflow.
- Reset mid-stream:
  - Stimulus: lane 1 holds 3 buffered words; pulse reset=0 for 1 edge.
  - Required: the next edge shows all outputs 0 and FIFOs empty; no stale word is emitted after release.

Source files
------------

// File: rtl/demux_lanes.sv
// demux_lanes: receive-side two-lane demultiplexer.
// Steers each valid word of the 2f byte stream to lane 0 or lane 1 through a
// small per-lane holding FIFO. Runs on clk8f with an internally derived
// word-rate strobe (one edge in four).
module demux_lanes #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk8f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_c,
    input  logic              valid_in_c,
    input  logic              lane_in_c,
    input  logic              pause_0,
    input  logic              pause_1,
    output logic [DATA_W-1:0] data_out_0_c,
    output logic              valid_out_0_c,
    output logic [DATA_W-1:0] data_out_1_c,
    output logic              valid_out_1_c,
    output logic              overflow_0,
    output logic              overflow_1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_WAIT  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_phase;
    logic              w_strobe;
    logic              w_active;

    // Per-lane storage and bookkeeping, index 0 = lane 0, index 1 = lane 1.
    logic [DATA_W-1:0] r_mem [2][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [2];
    logic [PTR_W-1:0]  r_rd_ptr [2];
    logic [PTR_W:0]    r_count [2];
    logic [DATA_W-1:0] r_data_out [2];
    logic [1:0]        r_valid_out;
    logic [1:0]        r_overflow;

    logic [1:0]        w_hit;
    logic [1:0]        w_pause;
    logic [1:0]        w_full;
    logic [1:0]        w_empty;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_drop;

    assign w_strobe = (r_phase == 2'd3);
    assign w_active = w_strobe && (r_state != S_RESET);
    assign w_hit    = {valid_in_c & lane_in_c, valid_in_c & ~lane_in_c};
    assign w_pause  = {pause_1, pause_0};

    // State register; reset is synchronous so it is just another branch here.
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk8f) begin
        if (!reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave RESET immediately, arm RUN on the first strobe.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RESET: w_state_next = S_WAIT;
            S_WAIT:  if (w_strobe) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_RESET;
        endcase
    end

    // Phase counter: counts every edge with reset released, strobe at phase 3.
    always_ff @(posedge clk8f) begin
        if (!reset) begin
            r_phase <= 2'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
        end
    end

    // Per-lane push/pop decisions; a full lane still accepts when it pops too.
    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_push  = '0;
        w_pop   = '0;
        w_drop  = '0;
        for (int l = 0; l < 2; l++) begin
            w_full[l]  = (r_count[l] == CNT_FULL);
            w_empty[l] = (r_count[l] == '0);
            w_pop[l]   = w_active && !w_empty[l] && !w_pause[l];
            w_push[l]  = w_active && w_hit[l] && (!w_full[l] || w_pop[l]);
            w_drop[l]  = w_active && w_hit[l] && w_full[l] && !w_pop[l];
        end
    end

    // FIFO storage write; a simultaneous pop reads the old head on this edge.
    // NOTE: the data array is not reset; pointers and counts define its contents.
    always_ff @(posedge clk8f) begin
        for (int l = 0; l < 2; l++) begin
            if (w_push[l]) begin
                r_mem[l][r_wr_ptr[l]] <= data_in_c;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow flags.
    always_ff @(posedge clk8f) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                r_wr_ptr[l] <= '0;
                r_rd_ptr[l] <= '0;
                r_count[l]  <= '0;
            end
            r_overflow <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (w_push[l]) r_wr_ptr[l] <= r_wr_ptr[l] + PTR_ONE;
                if (w_pop[l])  r_rd_ptr[l] <= r_rd_ptr[l] + PTR_ONE;
                case ({w_push[l], w_pop[l]})
                    2'b10:   r_count[l] <= r_count[l] + CNT_ONE;
                    2'b01:   r_count[l] <= r_count[l] - CNT_ONE;
                    default: r_count[l] <= r_count[l];
                endcase
                if (w_drop[l]) r_overflow[l] <= 1'b1;
            end
        end
    end

    // Output registers: refreshed only on strobe edges, zero when nothing pops.
    always_ff @(posedge clk8f) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                r_data_out[l] <= '0;
            end
            r_valid_out <= '0;
        end else if (w_active) begin
            for (int l = 0; l < 2; l++) begin
                if (w_pop[l]) begin
                    r_data_out[l]  <= r_mem[l][r_rd_ptr[l]];
                    r_valid_out[l] <= 1'b1;
                end else begin
                    r_data_out[l]  <= '0;
                    r_valid_out[l] <= 1'b0;
                end
            end
        end
    end

    assign data_out_0_c  = r_data_out[0];
    assign valid_out_0_c = r_valid_out[0];
    assign data_out_1_c  = r_data_out[1];
    assign valid_out_1_c = r_valid_out[1];
    assign overflow_0    = r_overflow[0];
    assign overflow_1    = r_overflow[1];

endmodule

// File: tb/tb_demux_lanes.sv
// tb_demux_lanes: directed-vector bench for demux_lanes with hand-computed
// expected values. Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, away from the active edge.
module tb_demux_lanes;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk8f = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in_c;
    logic              valid_in_c;
    logic              lane_in_c;
    logic              pause_0;
    logic              pause_1;
    logic [DATA_W-1:0] data_out_0_c;
    logic              valid_out_0_c;
    logic [DATA_W-1:0] data_out_1_c;
    logic              valid_out_1_c;
    logic              overflow_0;
    logic              overflow_1;

    int n_vec = 0;
    int n_err = 0;

    demux_lanes #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk8f        (clk8f),
        .reset        (reset),
        .data_in_c    (data_in_c),
        .valid_in_c   (valid_in_c),
        .lane_in_c    (lane_in_c),
        .pause_0      (pause_0),
        .pause_1      (pause_1),
        .data_out_0_c (data_out_0_c),
        .valid_out_0_c(valid_out_0_c),
        .data_out_1_c (data_out_1_c),
        .valid_out_1_c(valid_out_1_c),
        .overflow_0   (overflow_0),
        .overflow_1   (overflow_1)
    );

    always #5 clk8f = ~clk8f;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 ns.
    task automatic tick();
        @(posedge clk8f);
        #1;
    endtask

    // Called just before a strobe edge: present inputs for that strobe, run
    // the full word period, and return just before the next strobe edge.
    task automatic word(input logic v, input logic lane, input logic [7:0] d,
                        input logic p0, input logic p1);
        valid_in_c = v;
        lane_in_c  = lane;
        data_in_c  = d;
        pause_0    = p0;
        pause_1    = p1;
        tick();
        valid_in_c = 1'b0;
        data_in_c  = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic check_lane0(input string tag, input logic v, input logic [7:0] d);
        check({tag, ".v0"}, 32'(valid_out_0_c), 32'(v));
        check({tag, ".d0"}, 32'(data_out_0_c), 32'(d));
    endtask

    task automatic check_lane1(input string tag, input logic v, input logic [7:0] d);
        check({tag, ".v1"}, 32'(valid_out_1_c), 32'(v));
        check({tag, ".d1"}, 32'(data_out_1_c), 32'(d));
    endtask

    initial begin
        // ---- Reset check: 8 edges in reset with valid traffic present ----
        reset      = 1'b0;
        valid_in_c = 1'b1;
        lane_in_c  = 1'b0;
        data_in_c  = 8'h99;
        pause_0    = 1'b0;
        pause_1    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rst_hold%0d", i),
                  {14'd0, valid_out_0_c, data_out_0_c, valid_out_1_c, data_out_1_c,
                   overflow_0, overflow_1}, 32'd0);
        end

        // Release with a lane 0 word held on the input; only edge 4 may sample it.
        data_in_c = 8'h77;
        reset     = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("rel_e%0d.v0", e), 32'(valid_out_0_c), 32'd0);
        end
        tick();                          // edge 4: first strobe, samples 0x77
        valid_in_c = 1'b0;
        data_in_c  = '0;
        check("rel_e4.v0", 32'(valid_out_0_c), 32'd0);
        for (int e = 5; e <= 7; e++) begin
            tick();
            check($sformatf("rel_e%0d.v0", e), 32'(valid_out_0_c), 32'd0);
        end
        tick();                          // edge 8: second strobe, 0x77 appears
        check_lane0("rel_e8", 1'b1, 8'h77);
        tick();
        tick();
        tick();
        check_lane0("rel_hold", 1'b1, 8'h77);

        // ---- Alternating lanes ----
        word(1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
        check_lane0("alt1", 1'b0, 8'h00);
        check_lane1("alt1", 1'b0, 8'h00);
        word(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
        check_lane0("alt2", 1'b1, 8'hA1);
        check_lane1("alt2", 1'b0, 8'h00);
        word(1'b1, 1'b0, 8'hA3, 1'b0, 1'b0);
        check_lane0("alt3", 1'b0, 8'h00);
        check_lane1("alt3", 1'b1, 8'hB2);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("alt4", 1'b1, 8'hA3);
        check_lane1("alt4", 1'b0, 8'h00);

        // ---- Pause buffering on lane 0 ----
        word(1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
        check_lane0("pb_in1", 1'b0, 8'h00);
        word(1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
        word(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        check_lane0("pb_in3", 1'b0, 8'h00);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("pb_out1", 1'b1, 8'h11);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("pb_out2", 1'b1, 8'h22);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("pb_out3", 1'b1, 8'h33);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("pb_done", 1'b0, 8'h00);
        check("pb_ovf0", 32'(overflow_0), 32'd0);

        // ---- Overflow on lane 1: five words into a depth-4 FIFO ----
        for (int i = 1; i <= 5; i++) begin
            word(1'b1, 1'b1, 8'(i), 1'b0, 1'b1);
            check($sformatf("ov_in%0d.ovf1", i), 32'(overflow_1), (i == 5) ? 32'd1 : 32'd0);
        end
        check_lane1("ov_paused", 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check_lane1($sformatf("ov_out%0d", i), 1'b1, 8'(i));
        end
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane1("ov_drop", 1'b0, 8'h00);
        check("ov_sticky", 32'(overflow_1), 32'd1);
        check("ov_lane0_clean", 32'(overflow_0), 32'd0);

        // ---- Full lane 0 with simultaneous push and pop ----
        word(1'b1, 1'b0, 8'hC1, 1'b1, 1'b0);
        word(1'b1, 1'b0, 8'hC2, 1'b1, 1'b0);
        word(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
        word(1'b1, 1'b0, 8'hC4, 1'b1, 1'b0);
        word(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        check_lane0("fp_pp", 1'b1, 8'hC1);
        check("fp_pp.ovf0", 32'(overflow_0), 32'd0);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("fp_o2", 1'b1, 8'hC2);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("fp_o3", 1'b1, 8'hC3);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("fp_o4", 1'b1, 8'hC4);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("fp_o5", 1'b1, 8'h5A);
        word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_lane0("fp_empty", 1'b0, 8'h00);
        check("fp_ovf0", 32'(overflow_0), 32'd0);

        // ---- Reset mid-stream: lane 1 holds three words, lane 0 is driving ----
        word(1'b1, 1'b1, 8'hD1, 1'b0, 1'b1);
        word(1'b1, 1'b1, 8'hD2, 1'b0, 1'b1);
        word(1'b1, 1'b0, 8'hE1, 1'b0, 1'b1);
        word(1'b1, 1'b1, 8'hD3, 1'b0, 1'b1);
        check_lane0("mr_pre", 1'b1, 8'hE1);
        reset = 1'b0;
        tick();
        check("mr_rst_outs",
              {14'd0, valid_out_0_c, data_out_0_c, valid_out_1_c, data_out_1_c,
               overflow_0, overflow_1}, 32'd0);
        reset   = 1'b1;
        pause_1 = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            word(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check_lane1($sformatf("mr_post%0d", i), 1'b0, 8'h00);
            check_lane0($sformatf("mr_post%0d", i), 1'b0, 8'h00);
        end
        check("mr_ovf1_cleared", 32'(overflow_1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
